// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency RAM between the
// instruction-fetch and data-access stages. Data accesses win ties. The block
// drives the RAM en/ready handshake, returns read data with a one-cycle done
// pulse, generates pipeline stalls, and flags a RAM that never answers.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              stallIF,
    output logic              stallMEM,
    output logic              bus_err
);

    // The counter only has to reach TIMEOUT-1 before the access is aborted.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_done;
    logic              r_d_done;
    logic              r_bus_err;

    logic              w_d_elig;
    logic              w_if_elig;
    logic              w_finish;
    logic [DATA_W-1:0] w_ret_data;

    // A requester being retired this cycle (done high) must not be re-granted.
    assign w_d_elig   = d_req  & ~r_d_done;
    assign w_if_elig  = if_req & ~r_if_done;
    assign w_finish   = ram_ready | (r_cnt == CNT_LAST);
    assign w_ret_data = ram_ready ? ram_rdata : '0;

    // Arbitration FSM; owns every registered RAM-side and requester-side output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_d_elig) begin
                        r_state     <= S_DATA;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= d_we;
                        r_ram_addr  <= d_addr;
                        r_ram_wdata <= d_wdata;
                    end else if (w_if_elig) begin
                        r_state    <= S_FETCH;
                        r_ram_en   <= 1'b1;
                        r_ram_we   <= 1'b0;
                        r_ram_addr <= if_addr;
                    end
                end
                S_FETCH, S_DATA: begin
                    if (w_finish) begin
                        r_state  <= S_IDLE;
                        r_ram_en <= 1'b0;
                        r_ram_we <= 1'b0;
                        r_cnt    <= '0;
                        if (!ram_ready) begin
                            r_bus_err <= 1'b1;
                        end
                        if (r_state == S_FETCH) begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= w_ret_data;
                        end else begin
                            r_d_done <= 1'b1;
                            // Stores leave the last load result untouched.
                            if (!r_ram_we) begin
                                r_d_rdata <= w_ret_data;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_ram_en <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_done   = r_if_done;
    assign d_done    = r_d_done;
    assign bus_err   = r_bus_err;

    // Stalls follow outstanding requests; a data stall freezes fetch as well.
    assign stallMEM = ~rst & d_req & ~r_d_done;
    assign stallIF  = ~rst & (stallMEM | (if_req & ~r_if_done));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port memory between instruction fetch (IF stage) and data access (MEM stage) in the Antares-R2 pipelined datapath.
- Sequences the variable-latency RAM through an en/ready handshake.
- Returns read data to the winning requester and generates pipeline stall signals while requests are outstanding.
- A watchdog flags a RAM that never answers.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 16, max BUSY cycles waiting for ram_ready before abort (≥1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request; held until if_done
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, valid when if_done
if_done  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held until d_done
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid when d_done
d_done  out  1  one-cycle data completion pulse
ram_en  out  1  RAM access active
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid with ram_ready
ram_ready  in  1  RAM completes current access this cycle
stallIF  out  1  freeze PC/IF-ID
stallMEM  out  1  freeze whole pipeline (EX/MEM, MEM/WB included)
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, if_rdata=0, d_rdata=0, if_done=0, d_done=0, bus_err=0, timeout counter=0. rst overrides everything, including mid-access: the access is dropped, no done pulse is issued, and the requester re-requests.
- States: IDLE, FETCH, DATA.
- IDLE: a requester is eligible if req=1 and its done=0 this cycle. This prevents re-granting a request being retired.
  - d eligible → latch d_addr/d_wdata/d_we, go to DATA. Data has fixed priority: it is the older instruction.
  - else if eligible → latch if_addr (we=0), go to FETCH.
  - else stay.
- FETCH/DATA: ram_en=1, ram_we=latched we (0 in FETCH), ram_addr/ram_wdata=latched values, held stable all BUSY cycles. Counter increments each cycle.
  - ram_ready=1: capture ram_rdata into if_rdata (FETCH) or d_rdata (DATA, loads only; stores leave d_rdata unchanged). Next cycle: the matching done=1 for exactly one cycle, state=IDLE, counter=0.
  - No ready and counter==TIMEOUT-1: abort. Next cycle: done pulses, rdata=0 (loads/fetch), bus_err=1 (sticky until rst), state=IDLE.
- ram_en/ram_we/ram_addr/ram_wdata are registered. Outside BUSY: ram_en=0, ram_we=0; addr/wdata hold their last values.
- Latency: request sampled in IDLE at cycle N → ram_en=1 at N+1. ram_ready at cycle M → done and rdata at M+1. Minimum is done at N+2 (ready in the first BUSY cycle).
- Back-to-back: after a done cycle, arbitration resumes in IDLE. With both requests pending, the order is data then fetch. A continuous d_req stream cannot starve fetch, because d must drop req on its done cycle and fetch is then eligible.
- Stalls, combinational from registered state:
  - stallMEM = d_req & ~d_done.
  - stallIF = stallMEM | (if_req & ~if_done).
  - Both are 0 during reset.
- Simultaneous if_req and d_req rising in the same IDLE cycle: DATA is granted, and stallIF stays high throughout both accesses.

Test Plan:
1. Lone fetch: if_req=1, if_addr=0x40; RAM answers ready on 1st BUSY cycle with 0xDEADBEEF → ram_en at N+1, if_done and if_rdata=0xDEADBEEF at N+2, stallIF high N..N+1, low at N+2.
2. Collision: if_req and d_req (load 0x100) both at N; RAM latency 3 cycles → DATA served first (ram_addr=0x100), d_done at N+4, then FETCH granted at N+4 (IDLE), if_done at N+8. stallMEM low from N+4.
3. Store: d_req=1, d_we=1, d_addr=0x200, d_wdata=0x12345678 → ram_we=1 with matching addr/wdata held until ready; d_done pulses; d_rdata unchanged.
4. Timeout: TIMEOUT=4, ram_ready tied 0, load request → ram_en high 4 cycles, then d_done pulse with d_rdata=0 and bus_err=1. bus_err remains 1 after further successful accesses until rst.
5. Reset mid-access: assert rst in 2nd BUSY cycle → next cycle ram_en=0, no done pulse, bus_err=0, state IDLE. A held request is re-granted after rst deasserts.
6. No double grant: requester drops req exactly on its done cycle; the other request is idle → no second ram_en burst for the retired request.
